// File: rtl/dspl_pkg.sv
// Shared constants, types and the hex-to-7-segment decoder for the display driver.
package dspl_pkg;

  // Bit positions inside one 6-bit digit field
  localparam int DIG_EN     = 5;
  localparam int DIG_VAL_HI = 4;
  localparam int DIG_VAL_LO = 1;
  localparam int DIG_DP     = 0;

  // All segments and dp dark (active-low)
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    PH_ON,
    PH_OFF
  } blink_phase_t;

  // Active-low segments, bit 6 = a ... bit 0 = g
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dspl_drv_ndig_if.sv
// Application-to-driver bundle: digit data, blink/brightness controls, board pins.
interface dspl_drv_ndig_if #(
  parameter int NUM_DIGITS = 8,
  parameter int DIM_BITS   = 3
);
  logic [6*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [DIM_BITS-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              dec_ddp;

  // Application side
  modport master (
    output digits, blink_mask, brightness,
    input  an, dec_ddp
  );

  // Display driver side
  modport slave (
    input  digits, blink_mask, brightness,
    output an, dec_ddp
  );
endinterface

// File: rtl/dspl_tick_gen.sv
// Clock-enable generator: prescaler to sub-slot ticks, sub-slot counter to slot ticks.
module dspl_tick_gen #(
  parameter int SUB_DIV  = 8,   // clocks per sub-slot, must be >= 2
  parameter int DIM_BITS = 3
) (
  input  logic                clock,
  input  logic                reset,
  output logic                sub_tick,
  output logic                slot_tick,
  output logic [DIM_BITS-1:0] subslot
);

  localparam int PRE_W = $clog2(SUB_DIV);

  logic [PRE_W-1:0] pre;

  assign sub_tick  = (pre == PRE_W'(SUB_DIV - 1));
  assign slot_tick = sub_tick && (subslot == '1);

  // Prescaler 0..SUB_DIV-1; sub-slot counter wraps naturally at 2**DIM_BITS
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre     <= '0;
      subslot <= '0;
    end else begin
      pre <= sub_tick ? '0 : pre + 1'b1;
      if (sub_tick) subslot <= subslot + 1'b1;
    end
  end

endmodule

// File: rtl/dspl_drv_ndig.sv
// N-digit multiplexed 7-segment driver with per-digit blink and PWM brightness.
module dspl_drv_ndig
  import dspl_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int REFRESH_HZ  = 1000,
  parameter int DIM_BITS    = 3,
  parameter int BLINK_SLOTS = 500
) (
  input logic            clock,
  input logic            reset,
  dspl_drv_ndig_if.slave bus
);

  localparam int SUB_DIV = CLK_FREQ_HZ / (REFRESH_HZ * (2 ** DIM_BITS));
  localparam int SEL_W   = $clog2(NUM_DIGITS);
  localparam int BLK_W   = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

  logic                sub_tick;
  logic                slot_tick;
  logic [DIM_BITS-1:0] subslot;

  dspl_tick_gen #(
    .SUB_DIV  (SUB_DIV),
    .DIM_BITS (DIM_BITS)
  ) u_tick (
    .clock     (clock),
    .reset     (reset),
    .sub_tick  (sub_tick),
    .slot_tick (slot_tick),
    .subslot   (subslot)
  );

  // sel is the digit to be latched at the next slot start; cur_sel is the one on display
  logic [SEL_W-1:0]      sel, sel_n;
  logic [SEL_W-1:0]      cur_sel, cur_n;
  logic                  en_q, en_n;
  logic [3:0]            val_q, val_n;
  logic                  dp_q, dp_n;
  logic                  blink_q, blink_n;
  logic [DIM_BITS-1:0]   bright_q, bright_n;
  blink_phase_t          phase, phase_n;
  logic [BLK_W-1:0]      blink_cnt, blink_cnt_n;
  logic [NUM_DIGITS-1:0] an_q, an_n;
  logic [7:0]            dec_q, dec_n;
  logic [5:0]            fld;
  logic [DIM_BITS-1:0]   subslot_n;
  logic                  vis_n;

  assign bus.an      = an_q;
  assign bus.dec_ddp = dec_q;

  // Next-state logic; outputs are derived from next-state values so that anode and
  // segments switch on the same edge that starts the slot.
  always_comb begin
    sel_n       = sel;
    cur_n       = cur_sel;
    en_n        = en_q;
    val_n       = val_q;
    dp_n        = dp_q;
    blink_n     = blink_q;
    bright_n    = bright_q;
    phase_n     = phase;
    blink_cnt_n = blink_cnt;
    dec_n       = dec_q;
    an_n        = '1;
    fld         = bus.digits[6*sel +: 6];

    if (slot_tick) begin
      cur_n    = sel;
      sel_n    = (sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel + 1'b1;
      en_n     = fld[DIG_EN];
      val_n    = fld[DIG_VAL_HI:DIG_VAL_LO];
      dp_n     = fld[DIG_DP];
      blink_n  = bus.blink_mask[sel];
      bright_n = bus.brightness;
      if (blink_cnt == BLK_W'(BLINK_SLOTS - 1)) begin
        blink_cnt_n = '0;
        phase_n     = (phase == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        blink_cnt_n = blink_cnt + 1'b1;
      end
    end

    subslot_n = sub_tick ? subslot + 1'b1 : subslot;
    vis_n     = en_n & ~(blink_n & (phase_n == PH_OFF));

    if (vis_n && (subslot_n <= bright_n)) an_n[cur_n] = 1'b0;
    if (slot_tick) dec_n = vis_n ? {hex7seg(val_n), dp_n} : SEG_BLANK;
  end

  // Scan, latched digit, blink phase and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel       <= '0;
      cur_sel   <= '0;
      en_q      <= 1'b0;
      val_q     <= '0;
      dp_q      <= 1'b1;
      blink_q   <= 1'b0;
      bright_q  <= '0;
      phase     <= PH_ON;
      blink_cnt <= '0;
      an_q      <= '1;
      dec_q     <= SEG_BLANK;
    end else begin
      sel       <= sel_n;
      cur_sel   <= cur_n;
      en_q      <= en_n;
      val_q     <= val_n;
      dp_q      <= dp_n;
      blink_q   <= blink_n;
      bright_q  <= bright_n;
      phase     <= phase_n;
      blink_cnt <= blink_cnt_n;
      an_q      <= an_n;
      dec_q     <= dec_n;
    end
  end

endmodule

// File: tb/tb_dspl_drv_ndig.sv
// Scoreboard bench for dspl_drv_ndig: 4 digits, 32-clock slots, 8-clock sub-slots.
module tb_dspl_drv_ndig;

  localparam int ND   = 4;
  localparam int DB   = 2;
  localparam int SLOT = 32;
  localparam int SUB  = 8;

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    logic [3:0] an;
    logic [7:0] dec;
    int         low;
  } slot_exp_t;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  dspl_drv_ndig_if #(.NUM_DIGITS(ND), .DIM_BITS(DB)) bus ();

  dspl_drv_ndig #(
    .NUM_DIGITS  (ND),
    .CLK_FREQ_HZ (64),
    .REFRESH_HZ  (2),
    .DIM_BITS    (DB),
    .BLINK_SLOTS (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  slot_exp_t  sb[$];
  int         errors = 0;
  int         checks = 0;
  int         slot_num = 0;
  logic [3:0] val [ND];
  logic       en  [ND];
  logic       dp  [ND];

  task automatic apply_digits();
    for (int i = 0; i < ND; i++) bus.digits[6*i +: 6] = {en[i], val[i], dp[i]};
  endtask

  // Expected result for the next slot, from the inputs as they stand at slot start
  task automatic push_exp();
    slot_exp_t e;
    int  k, d;
    bit  off, vis;
    k   = slot_num + 1;
    d   = (k - 1) % ND;
    off = ((k / 8) % 2) == 1;
    vis = en[d] && !(bus.blink_mask[d] && off);
    e.an  = 4'hF;
    if (vis) e.an[d] = 1'b0;
    e.dec = vis ? {SEG[val[d]], dp[d]} : 8'hFF;
    e.low = vis ? (int'(bus.brightness) + 1) * SUB : 0;
    sb.push_back(e);
  endtask

  // Push expectation, watch one full slot, pop expectation. mid: 1 = brightness->1,
  // 2 = digit 1 value->9, applied halfway through the slot.
  task automatic run_slot(input int mid, output slot_exp_t e, output logic [3:0] an_seen,
                          output logic [7:0] dec_seen, output int low, output bit steady);
    push_exp();
    an_seen  = 4'hF;
    dec_seen = 8'h00;
    low      = 0;
    steady   = 1'b1;
    for (int c = 0; c < SLOT; c++) begin
      @(negedge clock);
      if (c == 0) dec_seen = bus.dec_ddp;
      else if (bus.dec_ddp !== dec_seen) steady = 1'b0;
      if (bus.an !== 4'hF) begin
        if (an_seen === 4'hF) an_seen = bus.an;
        else if (bus.an !== an_seen) steady = 1'b0;
        if (low != c) steady = 1'b0;
        low++;
      end
      if (c == 16 && mid == 1) bus.brightness = 2'd1;
      if (c == 16 && mid == 2) begin
        val[1] = 4'h9;
        apply_digits();
      end
    end
    slot_num++;
    e = sb.pop_front();
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (SLOT - 1) @(negedge clock);
    slot_num = 0;
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    #12;
    checks++;
    if (bus.an !== 4'hF) begin
      errors++;
      $display("FAIL reset_an: got %b want 1111", bus.an);
    end
    checks++;
    if (bus.dec_ddp !== 8'hFF) begin
      errors++;
      $display("FAIL reset_dec: got %h want ff", bus.dec_ddp);
    end
    @(negedge clock);
    reset = 1'b0;
    bad = 0;
    repeat (SLOT - 1) begin
      @(negedge clock);
      if (bus.an !== 4'hF || bus.dec_ddp !== 8'hFF) bad++;
    end
    slot_num = 0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pre_first_slot_blank: got %0d lit cycles want 0", bad);
    end
  endtask

  task automatic test_scan();
    slot_exp_t e; logic [3:0] a; logic [7:0] d; int l; bit s;
    for (int n = 0; n < 5; n++) begin
      run_slot(0, e, a, d, l, s);
      checks += 4;
      if (a !== e.an) begin errors++; $display("FAIL scan_an slot%0d: got %b want %b", slot_num, a, e.an); end
      if (d !== e.dec) begin errors++; $display("FAIL scan_dec slot%0d: got %b want %b", slot_num, d, e.dec); end
      if (l != e.low) begin errors++; $display("FAIL scan_low slot%0d: got %0d want %0d", slot_num, l, e.low); end
      if (!s) begin errors++; $display("FAIL scan_steady slot%0d: got unsteady want steady", slot_num); end
    end
  endtask

  task automatic test_disabled();
    slot_exp_t e; logic [3:0] a; logic [7:0] d; int l; bit s;
    en[2] = 1'b0;
    apply_digits();
    for (int n = 0; n < ND; n++) begin
      run_slot(0, e, a, d, l, s);
      checks += 3;
      if (a !== e.an) begin errors++; $display("FAIL disabled_an slot%0d: got %b want %b", slot_num, a, e.an); end
      if (d !== e.dec) begin errors++; $display("FAIL disabled_dec slot%0d: got %b want %b", slot_num, d, e.dec); end
      if (l != e.low) begin errors++; $display("FAIL disabled_low slot%0d: got %0d want %0d", slot_num, l, e.low); end
    end
    en[2] = 1'b1;
    apply_digits();
  endtask

  task automatic test_brightness();
    slot_exp_t e; logic [3:0] a; logic [7:0] d; int l; bit s;
    bus.brightness = 2'd0;
    for (int n = 0; n < 8; n++) begin
      // brightness switches to 1 halfway through slot 4; the slot keeps its latched value
      run_slot((n == 3) ? 1 : 0, e, a, d, l, s);
      checks += 3;
      if (a !== e.an) begin errors++; $display("FAIL bright_an slot%0d: got %b want %b", slot_num, a, e.an); end
      if (l != e.low) begin errors++; $display("FAIL bright_low slot%0d: got %0d want %0d", slot_num, l, e.low); end
      if (!s) begin errors++; $display("FAIL bright_steady slot%0d: got unsteady want steady", slot_num); end
    end
    bus.brightness = 2'd3;
  endtask

  task automatic test_mid_change();
    slot_exp_t e; logic [3:0] a; logic [7:0] d; int l; bit s;
    int guard;
    guard = 0;
    while (slot_num % ND != 1 && guard < ND) begin
      run_slot(0, e, a, d, l, s);
      guard++;
    end
    for (int n = 0; n < ND + 1; n++) begin
      run_slot((n == 0) ? 2 : 0, e, a, d, l, s);
      checks += 2;
      if (a !== e.an) begin errors++; $display("FAIL midchg_an slot%0d: got %b want %b", slot_num, a, e.an); end
      if (d !== e.dec) begin errors++; $display("FAIL midchg_dec slot%0d: got %b want %b", slot_num, d, e.dec); end
    end
    val[1] = 4'h2;
    apply_digits();
  endtask

  task automatic test_blink();
    slot_exp_t e; logic [3:0] a; logic [7:0] d; int l; bit s;
    @(negedge clock);
    reset = 1'b1;
    bus.blink_mask = 4'b0001;
    release_reset();
    for (int n = 0; n < 24; n++) begin
      run_slot(0, e, a, d, l, s);
      checks += 2;
      if (a !== e.an) begin errors++; $display("FAIL blink_an slot%0d: got %b want %b", slot_num, a, e.an); end
      if (d !== e.dec) begin errors++; $display("FAIL blink_dec slot%0d: got %b want %b", slot_num, d, e.dec); end
    end
    bus.blink_mask = 4'b0000;
  endtask

  task automatic test_async_reset();
    slot_exp_t e; logic [3:0] a; logic [7:0] d; int l; bit s;
    @(negedge clock);
    reset = 1'b1;
    release_reset();
    run_slot(0, e, a, d, l, s);
    repeat (10) @(negedge clock);
    checks++;
    if (bus.an !== 4'b1101) begin
      errors++;
      $display("FAIL areset_before: got %b want 1101", bus.an);
    end
    #2 reset = 1'b1;
    #1;
    checks += 2;
    if (bus.an !== 4'hF) begin errors++; $display("FAIL areset_an: got %b want 1111", bus.an); end
    if (bus.dec_ddp !== 8'hFF) begin errors++; $display("FAIL areset_dec: got %h want ff", bus.dec_ddp); end
    sb.delete();
    release_reset();
    for (int n = 0; n < 2; n++) begin
      run_slot(0, e, a, d, l, s);
      checks += 2;
      if (a !== e.an) begin errors++; $display("FAIL after_areset_an slot%0d: got %b want %b", slot_num, a, e.an); end
      if (d !== e.dec) begin errors++; $display("FAIL after_areset_dec slot%0d: got %b want %b", slot_num, d, e.dec); end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < ND; i++) begin
      val[i] = 4'(i + 1);
      en[i]  = 1'b1;
      dp[i]  = 1'b1;
    end
    apply_digits();
    bus.blink_mask = 4'b0000;
    bus.brightness = 2'd3;

    test_reset();
    test_scan();
    test_disabled();
    test_brightness();
    test_mid_change();
    test_blink();
    test_async_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
